// File: rtl/cdc_handshake_tx.sv
`default_nettype none
// ============================================================================
// Module   : cdc_handshake_tx
// Purpose  : Source side of a four-phase req/ack clock-domain crossing. A word
//            accepted on a valid/ready interface is held on tx_data, tx_req is
//            raised, and the block waits for the remote (asynchronous) ack to
//            rise and then fall before reporting completion with done.
// Ports    : clk, rst              - clock, synchronous active-high reset
//            in_valid/in_ready     - accept handshake (in_ready combinational)
//            in_data               - word to send, sampled on the accept edge
//            tx_req, tx_data       - registered request and held data
//            tx_ack                - asynchronous ack from the remote domain
//            done                  - one-cycle pulse on transfer completion
//            busy                  - high whenever the FSM is not idle
//            err                   - one-cycle pulse on ack timeout
// Options  : ACK_TIMEOUT_EN        - enables the REQ/RELEASE timeout counter;
//                                    without it err is constant 0.
// Revision : 1.0 - initial release
// ============================================================================
module cdc_handshake_tx #(
    parameter int DATA_WIDTH     = 4,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  tx_req,
    output logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_ack,
    output logic                  done,
    output logic                  busy,
    output logic                  err
);

    // Elaboration-time guard on the configuration.
    if (SYNC_STAGES < 2 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("cdc_handshake_tx: SYNC_STAGES must be >= 2 and TIMEOUT_CYCLES >= 1");
    end

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SETUP   = 2'd1,
        S_REQ     = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic                    tx_req_q, tx_req_d;
    logic [DATA_WIDTH-1:0]   tx_data_q, tx_data_d;
    logic                    done_q, done_d;
    logic [SYNC_STAGES-1:0]  ack_sync_q;
    logic                    ack_sync;

    // Only the last synchroniser stage is ever looked at by the FSM.
    assign ack_sync = ack_sync_q[SYNC_STAGES-1];

`ifdef ACK_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             err_q, err_d;
    logic             timeout;

    // cnt_inc is the number of cycles spent in the waiting state including
    // the current one, so the abort fires after exactly TIMEOUT_CYCLES cycles.
    assign cnt_inc = cnt_q + 1'b1;
    assign timeout = (cnt_inc == CNT_W'(TIMEOUT_CYCLES));
`endif

    always_comb begin
        state_d   = state_q;
        tx_req_d  = tx_req_q;
        tx_data_d = tx_data_q;
        done_d    = 1'b0;
        in_ready  = 1'b0;
`ifdef ACK_TIMEOUT_EN
        cnt_d     = cnt_q;
        err_d     = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                // A stale ack (after reset or abort) must be released by the
                // remote before a new request can start.
                in_ready = ~ack_sync;
                if (in_valid && !ack_sync) begin
                    tx_data_d = in_data;
                    state_d   = S_SETUP;
                end
            end
            S_SETUP: begin
                tx_req_d = 1'b1;
                state_d  = S_REQ;
`ifdef ACK_TIMEOUT_EN
                cnt_d    = '0;
`endif
            end
            S_REQ: begin
                if (ack_sync) begin
                    tx_req_d = 1'b0;
                    state_d  = S_RELEASE;
`ifdef ACK_TIMEOUT_EN
                    cnt_d    = '0;
                end else if (timeout) begin
                    tx_req_d = 1'b0;
                    err_d    = 1'b1;
                    state_d  = S_IDLE;
                end else begin
                    cnt_d    = cnt_inc;
`endif
                end
            end
            S_RELEASE: begin
                if (!ack_sync) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
`ifdef ACK_TIMEOUT_EN
                end else if (timeout) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d   = cnt_inc;
`endif
                end
            end
            default: begin
                state_d  = S_IDLE;
                tx_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            tx_req_q   <= 1'b0;
            tx_data_q  <= '0;
            done_q     <= 1'b0;
            ack_sync_q <= '0;
        end else begin
            state_q    <= state_d;
            tx_req_q   <= tx_req_d;
            tx_data_q  <= tx_data_d;
            done_q     <= done_d;
            ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], tx_ack};
        end
    end

`ifdef ACK_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign tx_req  = tx_req_q;
    assign tx_data = tx_data_q;
    assign done    = done_q;
    assign busy    = (state_q != S_IDLE);

endmodule
`default_nettype wire
